// File: rtl/jtag_debug_cmd_sequencer_pkg.sv
// Shared definitions for the JTAG debug command sequencer.
//   - seq_state_t : sequencer FSM states
//   - DEF_*       : default widths for the sequencer parameters
//   - IR_*        : named instruction codes for the four action channels
package jtag_debug_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } seq_state_t;

    localparam int DEF_IR_WIDTH   = 2;
    localparam int DEF_SR_WIDTH   = 38;
    localparam int DEF_ACTION_BIT = 35;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

endpackage

// File: rtl/jtag_debug_cmd_sequencer_if.sv
// Command issue bus between the sequencer and its action consumer.
//   jdo            : latched command data
//   take_action    : one-hot action strobe, indexed by instruction
//   take_no_action : one-hot no-action strobe, indexed by instruction
//   busy           : a command is being issued
//   action_ready   : consumer accepts a held strobe (hold mode only)
// master = sequencer side, slave = consumer side.
interface jtag_debug_cmd_sequencer_if #(
    parameter int IR_WIDTH = 2,
    parameter int SR_WIDTH = 38
);
    localparam int NUM_IR = 1 << IR_WIDTH;

    logic [SR_WIDTH-1:0] jdo;
    logic [NUM_IR-1:0]   take_action;
    logic [NUM_IR-1:0]   take_no_action;
    logic                busy;
    logic                action_ready;

    modport master (
        output jdo,
        output take_action,
        output take_no_action,
        output busy,
        input  action_ready
    );

    modport slave (
        input  jdo,
        input  take_action,
        input  take_no_action,
        input  busy,
        output action_ready
    );

endinterface

// File: rtl/jtag_debug_cmd_sequencer_sync_edge.sv
// Brings an asynchronous level into clk and reports its rising edges.
//   clk, reset_n : system clock, asynchronous active-low reset
//   async_in     : level from another clock domain
//   rise         : one-cycle pulse, SYNC_STAGES+1 cycles after async_in rises
// The rise pulse is registered so downstream logic sees a clean flop output.
module jtag_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
            rise     <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
            hist_reg <= sync_reg[SYNC_STAGES-1];
            // A level held high yields a single pulse; it must fall to re-arm.
            rise     <= sync_reg[SYNC_STAGES-1] & ~hist_reg;
        end
    end

endmodule

// File: rtl/jtag_debug_cmd_sequencer.sv
// System-clock command sequencer for the CPU JTAG debug module.
// Synchronises update-IR / update-DR from the TCK domain, latches the
// shift register onto jdo and issues a one-hot take_action or
// take_no_action strobe on the channel selected by the instruction.
//   clk, reset_n  : system clock, asynchronous active-low reset
//   ir_in, sr     : instruction and shift register from the TCK domain
//   vs_udr/vs_uir : update-DR / update-IR levels (asynchronous)
//   clr_overrun   : clears the overrun sticky
//   overrun       : sticky, an update-DR arrived while busy and was dropped
//   cmd_count     : commands issued, wrapping
//   cmd           : command issue bus (jdo, strobes, busy, action_ready)
module jtag_debug_cmd_sequencer
    import jtag_debug_pkg::*;
#(
    parameter int IR_WIDTH    = DEF_IR_WIDTH,
    parameter int SR_WIDTH    = DEF_SR_WIDTH,
    parameter int ACTION_BIT  = DEF_ACTION_BIT,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_MODE   = 0,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IR_WIDTH-1:0]  ir_in,
    input  logic [SR_WIDTH-1:0]  sr,
    input  logic                 vs_udr,
    input  logic                 vs_uir,
    input  logic                 clr_overrun,
    output logic                 overrun,
    output logic [CNT_WIDTH-1:0] cmd_count,
    jtag_debug_cmd_sequencer_if.master cmd
);

    localparam int NUM_IR = 1 << IR_WIDTH;

    seq_state_t          state_reg;
    logic [IR_WIDTH-1:0] ir_latched_reg;
    logic                udr_evt;
    logic                uir_evt;
    logic [IR_WIDTH-1:0] sel_ir;
    logic [NUM_IR-1:0]   sel_onehot;
    logic                issue_done;

    jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_udr),
        .rise     (udr_evt)
    );

    jtag_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_uir),
        .rise     (uir_evt)
    );

    // When update-IR and update-DR land together the new instruction applies.
    assign sel_ir     = uir_evt ? ir_in : ir_latched_reg;
    assign sel_onehot = NUM_IR'(1) << sel_ir;

    // Pulse mode retires after one cycle; hold mode waits for the consumer.
    assign issue_done = (HOLD_MODE == 0) || cmd.action_ready;

    assign cmd.busy = (state_reg != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg          <= IDLE;
            ir_latched_reg     <= '0;
            cmd.jdo            <= '0;
            cmd.take_action    <= '0;
            cmd.take_no_action <= '0;
            overrun            <= 1'b0;
            cmd_count          <= '0;
        end else begin
            if (uir_evt) begin
                ir_latched_reg <= ir_in;
            end

            // Setting takes priority over clearing in the same cycle.
            if (udr_evt && (state_reg != IDLE)) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    cmd.take_action    <= '0;
                    cmd.take_no_action <= '0;
                    if (udr_evt) begin
                        cmd.jdo   <= sr;
                        state_reg <= ISSUE;
                        if (sr[ACTION_BIT]) begin
                            cmd.take_action <= sel_onehot;
                        end else begin
                            cmd.take_no_action <= sel_onehot;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_done) begin
                        state_reg          <= IDLE;
                        cmd.take_action    <= '0;
                        cmd.take_no_action <= '0;
                        cmd_count          <= cmd_count + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_reg          <= IDLE;
                    cmd.take_action    <= '0;
                    cmd.take_no_action <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_debug_cmd_sequencer.sv
// Self-checking bench: two sequencers (pulse mode u0, hold mode u1).
// Stimulus tasks push expected commands into per-DUT queues; a negedge
// monitor pops and compares whenever a strobe appears.
module tb_jtag_debug_cmd_sequencer;

    typedef struct {
        logic [37:0] jdo;
        logic [3:0]  act;
        logic [3:0]  noact;
        int          len;
        logic [7:0]  cnt;
        int          start;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic [1:0]  vs_udr;
    logic [1:0]  vs_uir;
    logic        clr_overrun;
    logic [1:0]  overrun;
    logic [7:0]  cmd_count0;
    logic [7:0]  cmd_count1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t       q0[$];
    exp_t       q1[$];
    exp_t       cur[2];
    bit         active[2];
    int         run[2];
    logic [7:0] exp_cnt[2];

    jtag_debug_cmd_sequencer_if #(.IR_WIDTH(2), .SR_WIDTH(38)) bus0 ();
    jtag_debug_cmd_sequencer_if #(.IR_WIDTH(2), .SR_WIDTH(38)) bus1 ();

    jtag_debug_cmd_sequencer #(.HOLD_MODE(0)) u0 (
        .clk         (clk),
        .reset_n     (reset_n),
        .ir_in       (ir_in),
        .sr          (sr),
        .vs_udr      (vs_udr[0]),
        .vs_uir      (vs_uir[0]),
        .clr_overrun (clr_overrun),
        .overrun     (overrun[0]),
        .cmd_count   (cmd_count0),
        .cmd         (bus0)
    );

    jtag_debug_cmd_sequencer #(.HOLD_MODE(1)) u1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .ir_in       (ir_in),
        .sr          (sr),
        .vs_udr      (vs_udr[1]),
        .vs_uir      (vs_uir[1]),
        .clr_overrun (clr_overrun),
        .overrun     (overrun[1]),
        .cmd_count   (cmd_count1),
        .cmd         (bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    function automatic logic [3:0] onehot(input logic [1:0] ir);
        logic [3:0] one;
        one = 4'b0001;
        return one << ir;
    endfunction

    task automatic push_exp(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor step for one DUT, called on every falling edge.
    task automatic mon(input int d, input logic [3:0] ta, input logic [3:0] tna,
                       input logic [37:0] j, input logic [7:0] cnt, input logic b);
        exp_t e;
        bit   empty;
        if (!reset_n) begin
            active[d] = 1'b0;
            return;
        end
        if (active[d]) begin
            if ((ta | tna) != 4'b0) begin
                run[d]++;
                chk($sformatf("u%0d strobe held", d), {ta, tna}, {cur[d].act, cur[d].noact});
            end else begin
                active[d] = 1'b0;
                chk($sformatf("u%0d strobe length", d), run[d], cur[d].len);
                chk($sformatf("u%0d cmd_count", d), cnt, cur[d].cnt);
            end
        end else if ((ta | tna) != 4'b0) begin
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                checks++;
                errors++;
                $display("FAIL u%0d unexpected strobe: got act=%b noact=%b required none", d, ta, tna);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                $display("u%0d cyc %0d: jdo=%h act=%b noact=%b", d, cyc, j, ta, tna);
                chk($sformatf("u%0d jdo", d), j, e.jdo);
                chk($sformatf("u%0d take_action", d), ta, e.act);
                chk($sformatf("u%0d take_no_action", d), tna, e.noact);
                chk($sformatf("u%0d busy", d), b, 1'b1);
                chk($sformatf("u%0d latency", d), cyc, e.start);
                cur[d]    = e;
                active[d] = 1'b1;
                run[d]    = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus0.take_action, bus0.take_no_action, bus0.jdo, cmd_count0, bus0.busy);
        mon(1, bus1.take_action, bus1.take_no_action, bus1.jdo, cmd_count1, bus1.busy);
    end

    // Caller sits on a falling edge; returns four falling edges later.
    task automatic udr(input int d, input logic [37:0] val, input bit push,
                       input logic [1:0] ir, input int len);
        exp_t e;
        if (push) begin
            exp_cnt[d] = exp_cnt[d] + 8'd1;
            e.jdo   = val;
            e.act   = val[35] ? onehot(ir) : 4'b0;
            e.noact = val[35] ? 4'b0 : onehot(ir);
            e.len   = len;
            e.cnt   = exp_cnt[d];
            e.start = cyc + 4;
            push_exp(d, e);
        end
        sr        = val;
        vs_udr[d] = 1'b1;
        repeat (2) @(negedge clk);
        vs_udr[d] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic uir(input int d, input logic [1:0] ir);
        ir_in     = ir;
        vs_uir[d] = 1'b1;
        repeat (2) @(negedge clk);
        vs_uir[d] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic hold_ready(input int delay);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if ((bus1.take_action | bus1.take_no_action) != 4'b0) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL u1 strobe timeout: got none required a strobe within 40 cycles");
        end else begin
            repeat (delay) @(negedge clk);
            bus1.action_ready = 1'b1;
            @(negedge clk);
            bus1.action_ready = 1'b0;
        end
    endtask

    initial begin
        bit seen;
        reset_n           = 1'b0;
        ir_in             = 2'b00;
        sr                = '0;
        vs_udr            = 2'b00;
        vs_uir            = 2'b00;
        clr_overrun       = 1'b0;
        bus0.action_ready = 1'b0;
        bus1.action_ready = 1'b0;
        exp_cnt[0]        = 8'd0;
        exp_cnt[1]        = 8'd0;
        active[0]         = 1'b0;
        active[1]         = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset jdo", bus0.jdo, 38'h0);
        chk("reset take_action", {bus1.take_action, bus0.take_action}, 8'h00);
        chk("reset take_no_action", {bus1.take_no_action, bus0.take_no_action}, 8'h00);
        chk("reset busy", {bus1.busy, bus0.busy}, 2'b00);
        chk("reset overrun", overrun, 2'b00);
        chk("reset cmd_count", {cmd_count1, cmd_count0}, 16'h0000);
        reset_n = 1'b1;
        @(negedge clk);

        // Pulse mode: no-action on channel 1, then action on channel 3
        uir(0, 2'b01);
        udr(0, 38'h20_0000_00AB, 1'b1, 2'b01, 1);
        repeat (2) @(negedge clk);
        uir(0, 2'b11);
        udr(0, 38'h08_1234_5678, 1'b1, 2'b11, 1);
        repeat (2) @(negedge clk);

        // Run the counter up to its last value
        for (int i = 0; i < 253; i++) begin
            udr(0, 38'(i), 1'b1, 2'b11, 1);
        end
        repeat (2) @(negedge clk);
        chk("u0 cmd_count at max", cmd_count0, 8'hFF);

        // Update-IR and update-DR together: new instruction 2 wins; count wraps
        ir_in     = 2'b10;
        sr        = 38'h00_0000_0C0D;
        exp_cnt[0] = exp_cnt[0] + 8'd1;
        push_exp(0, '{jdo: 38'h00_0000_0C0D, act: 4'b0000, noact: 4'b0100,
                      len: 1, cnt: 8'h00, start: cyc + 4});
        vs_udr[0] = 1'b1;
        vs_uir[0] = 1'b1;
        repeat (2) @(negedge clk);
        vs_udr[0] = 1'b0;
        vs_uir[0] = 1'b0;
        repeat (4) @(negedge clk);

        // Hold mode: strobe held 6 cycles; second update-DR dropped
        fork
            begin
                udr(1, 38'h08_0000_0001, 1'b1, 2'b00, 6);
                udr(1, 38'h00_DEAD_BEEF, 1'b0, 2'b00, 0);
            end
            hold_ready(5);
        join
        chk("u1 overrun after drop", overrun[1], 1'b1);
        chk("u1 jdo keeps first", bus1.jdo, 38'h08_0000_0001);
        chk("u1 busy after accept", bus1.busy, 1'b0);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        chk("u1 overrun cleared", overrun[1], 1'b0);

        // Drop coincides with clr_overrun: set wins
        fork
            begin
                udr(1, 38'h00_0000_0077, 1'b1, 2'b00, 6);
                udr(1, 38'h00_0000_0099, 1'b0, 2'b00, 0);
            end
            begin
                repeat (7) @(negedge clk);
                clr_overrun = 1'b1;
                @(negedge clk);
                clr_overrun = 1'b0;
            end
            hold_ready(5);
        join
        chk("u1 overrun set wins", overrun[1], 1'b1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        chk("u1 overrun cleared again", overrun[1], 1'b0);
        repeat (2) @(negedge clk);

        // Reset during a held strobe
        fork
            udr(1, 38'h08_0000_00E0, 1'b1, 2'b00, 99);
            begin
                seen = 1'b0;
                for (int i = 0; i < 40 && !seen; i++) begin
                    @(negedge clk);
                    if ((bus1.take_action | bus1.take_no_action) != 4'b0) seen = 1'b1;
                end
                chk("u1 strobe before reset", seen, 1'b1);
                @(negedge clk);
                #2 reset_n = 1'b0;
                #1;
                chk("mid-reset take_action", bus1.take_action, 4'b0);
                chk("mid-reset take_no_action", bus1.take_no_action, 4'b0);
                chk("mid-reset busy", bus1.busy, 1'b0);
                chk("mid-reset jdo", bus1.jdo, 38'h0);
                chk("mid-reset cmd_count", cmd_count1, 8'h00);
            end
        join
        @(negedge clk);
        #2 reset_n = 1'b1;
        exp_cnt[0] = 8'd0;
        exp_cnt[1] = 8'd0;
        repeat (20) @(negedge clk);
        chk("post-reset u1 idle", {bus1.busy, bus1.take_action, bus1.take_no_action}, 9'h000);

        fork
            udr(1, 38'h00_0000_0F0F, 1'b1, 2'b00, 1);
            hold_ready(0);
        join
        repeat (4) @(negedge clk);

        chk("u0 queue drained", q0.size(), 0);
        chk("u1 queue drained", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

endmodule
